// File: rtl/icache_line.sv
// Direct-mapped, read-only instruction cache with multi-word lines.
// A miss refills the whole line word by word (word 0 first) over a simple
// request/hready bus; an error response aborts the refill and is reported
// to the core. A flush walks the valid bits one line per cycle.
//
// Handshake: the core raises core_req_i with a stable core_addr_i and holds
// both until the single-cycle core_ready_o pulse. On the bus side,
// bus_req_o/bus_addr_o stay put until a cycle with hready_i=1, which accepts
// the word (hrdata_i valid in that same cycle, hresp_i=1 marks an error).
module icache_line #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_BITS  = 4,
    parameter int WORD_BITS   = 2,
    parameter int BYTE_OFFSET = 2,
    parameter int TAG_BITS    = DATA_WIDTH - INDEX_BITS - WORD_BITS - BYTE_OFFSET
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] core_addr_i,
    input  logic                  core_req_i,
    output logic                  core_ready_o,
    output logic [DATA_WIDTH-1:0] core_rdata_o,
    output logic                  core_err_o,
    output logic                  cache_hit_o,
    input  logic                  flush_i,
    output logic                  flush_busy_o,
    output logic                  bus_req_o,
    output logic [DATA_WIDTH-1:0] bus_addr_o,
    input  logic [DATA_WIDTH-1:0] hrdata_i,
    input  logic                  hready_i,
    input  logic                  hresp_i
);

    localparam int LINES   = 2 ** INDEX_BITS;
    localparam int WPL     = 2 ** WORD_BITS;
    localparam int TAG_LSB = INDEX_BITS + WORD_BITS + BYTE_OFFSET;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_REFILL,
        S_FLUSH
    } state_e;

    state_e                  state_q, state_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [WORD_BITS-1:0]    cnt_q, cnt_d;
    logic [INDEX_BITS-1:0]   flush_idx_q, flush_idx_d;
    logic                    sticky_q, sticky_d;
    logic [TAG_BITS-1:0]     rf_tag_q, rf_tag_d;
    logic [INDEX_BITS-1:0]   rf_idx_q, rf_idx_d;

    // Tag and data storage carry no reset; the valid bits guard them.
    logic [TAG_BITS-1:0]     tag_q  [LINES];
    logic [DATA_WIDTH-1:0]   data_q [LINES][WPL];

    logic                    data_we;
    logic                    tag_we;

    // Fields of the incoming fetch address.
    logic [TAG_BITS-1:0]     req_tag;
    logic [INDEX_BITS-1:0]   req_idx;
    logic [WORD_BITS-1:0]    req_word;
    logic                    hit;
    logic                    unused_byte_bits;

    assign req_tag          = core_addr_i[DATA_WIDTH-1:TAG_LSB];
    assign req_idx          = core_addr_i[TAG_LSB-1 -: INDEX_BITS];
    assign req_word         = core_addr_i[BYTE_OFFSET +: WORD_BITS];
    assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_byte_bits = ^core_addr_i[BYTE_OFFSET-1:0];

    // Next-state, storage control and all outputs; reset forces outputs to 0.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        cnt_d        = cnt_q;
        flush_idx_d  = flush_idx_q;
        sticky_d     = sticky_q;
        rf_tag_d     = rf_tag_q;
        rf_idx_d     = rf_idx_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        core_ready_o = 1'b0;
        core_rdata_o = '0;
        core_err_o   = 1'b0;
        cache_hit_o  = 1'b0;
        flush_busy_o = 1'b0;
        bus_req_o    = 1'b0;
        bus_addr_o   = '0;

        // A flush arriving while busy is remembered and served from IDLE.
        if (flush_i && (state_q != S_IDLE)) begin
            sticky_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (flush_i || sticky_q) begin
                    state_d     = S_FLUSH;
                    flush_idx_d = '0;
                end else if (core_req_i) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                cache_hit_o = hit;
                if (!core_req_i) begin
                    // Request withdrawn during a refill: finish quietly.
                    state_d = S_IDLE;
                end else if (hit) begin
                    core_ready_o = 1'b1;
                    core_rdata_o = data_q[req_idx][req_word];
                    state_d      = S_IDLE;
                end else begin
                    // Evict now so a failed refill leaves the line invalid.
                    valid_d[req_idx] = 1'b0;
                    cnt_d            = '0;
                    rf_tag_d         = req_tag;
                    rf_idx_d         = req_idx;
                    state_d          = S_REFILL;
                end
            end
            S_REFILL: begin
                bus_req_o  = 1'b1;
                bus_addr_o = {rf_tag_q, rf_idx_q, cnt_q, {BYTE_OFFSET{1'b0}}};
                if (hready_i && hresp_i) begin
                    core_ready_o = core_req_i;
                    core_err_o   = core_req_i;
                    state_d      = S_IDLE;
                end else if (hready_i) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == WORD_BITS'(WPL - 1)) begin
                        tag_we            = 1'b1;
                        valid_d[rf_idx_q] = 1'b1;
                        state_d           = S_COMPARE;
                    end
                end
            end
            S_FLUSH: begin
                flush_busy_o          = 1'b1;
                valid_d[flush_idx_q]  = 1'b0;
                flush_idx_d           = flush_idx_q + 1'b1;
                if (flush_idx_q == INDEX_BITS'(LINES - 1)) begin
                    sticky_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!reset_i) begin
            data_we      = 1'b0;
            tag_we       = 1'b0;
            core_ready_o = 1'b0;
            core_rdata_o = '0;
            core_err_o   = 1'b0;
            cache_hit_o  = 1'b0;
            flush_busy_o = 1'b0;
            bus_req_o    = 1'b0;
            bus_addr_o   = '0;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            cnt_q       <= '0;
            flush_idx_q <= '0;
            sticky_q    <= 1'b0;
            rf_tag_q    <= '0;
            rf_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            flush_idx_q <= flush_idx_d;
            sticky_q    <= sticky_d;
            rf_tag_q    <= rf_tag_d;
            rf_idx_q    <= rf_idx_d;
        end
    end

    // Line data and tag writes during refill.
    always_ff @(posedge clk_i) begin
        if (data_we) begin
            data_q[rf_idx_q][cnt_q] <= hrdata_i;
        end
        if (tag_we) begin
            tag_q[rf_idx_q] <= rf_tag_q;
        end
    end

endmodule

// File: tb/tb_icache_line.sv
// Bench for icache_line: directed fetches with hand-computed results, a bus
// responder returning hrdata = address, and a scoreboard monitor.
module tb_icache_line;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [W-1:0] core_addr_i;
    logic         core_req_i;
    logic         core_ready_o;
    logic [W-1:0] core_rdata_o;
    logic         core_err_o;
    logic         cache_hit_o;
    logic         flush_i;
    logic         flush_busy_o;
    logic         bus_req_o;
    logic [W-1:0] bus_addr_o;
    logic [W-1:0] hrdata_i;
    logic         hready_i;
    logic         hresp_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard entries: {err, hit, rdata}.
    logic [W+1:0] exp_q[$];
    logic [W-1:0] bus_q[$];

    // Bus responder controls.
    int wait_word = -1;
    int wait_left = 0;
    int err_word  = -1;

    icache_line dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .core_addr_i  (core_addr_i),
        .core_req_i   (core_req_i),
        .core_ready_o (core_ready_o),
        .core_rdata_o (core_rdata_o),
        .core_err_o   (core_err_o),
        .cache_hit_o  (cache_hit_o),
        .flush_i      (flush_i),
        .flush_busy_o (flush_busy_o),
        .bus_req_o    (bus_req_o),
        .bus_addr_o   (bus_addr_o),
        .hrdata_i     (hrdata_i),
        .hready_i     (hready_i),
        .hresp_i      (hresp_i)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_line(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus_q.push_back(base + W'(4 * i));
        end
    endtask

    // Driver: issue one fetch, wait (bounded) for ready, check latency.
    task automatic fetch(input logic [W-1:0] addr, input logic [W-1:0] exp_rdata,
                         input logic exp_err, input int exp_lat);
        int  k;
        bit  done;
        exp_q.push_back({exp_err, ~exp_err, exp_rdata});
        @(negedge clk_i);
        core_addr_i = addr;
        core_req_i  = 1'b1;
        k    = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            @(negedge clk_i);
            #2;
            k++;
            if (core_ready_o) done = 1'b1;
        end
        core_req_i = 1'b0;
        check("latency", W'(k), W'(exp_lat));
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ready"}, W'(core_ready_o), '0);
        check({name, "_err"},   W'(core_err_o),   '0);
        check({name, "_hit"},   W'(cache_hit_o),  '0);
        check({name, "_fbusy"}, W'(flush_busy_o), '0);
        check({name, "_breq"},  W'(bus_req_o),    '0);
        check({name, "_baddr"}, bus_addr_o,       '0);
        check({name, "_rdata"}, core_rdata_o,     '0);
    endtask

    // Bus responder: returns the address as data, with optional waits/error.
    initial begin : responder
        int w;
        hready_i = 1'b0;
        hresp_i  = 1'b0;
        hrdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (bus_req_o) begin
                w = int'(bus_addr_o[3:2]);
                if (w == wait_word && wait_left > 0) begin
                    hready_i = 1'b0;
                    hresp_i  = 1'b0;
                    wait_left--;
                    if (bus_q.size() > 0) begin
                        check("bus_addr_hold", bus_addr_o, bus_q[0]);
                    end else begin
                        n_checks++;
                        $display("FAIL bus_req: unexpected request at 0x%08h, expected none", bus_addr_o);
                    end
                end else begin
                    hready_i = 1'b1;
                    hresp_i  = (w == err_word);
                    hrdata_i = bus_addr_o;
                    if (bus_q.size() > 0) begin
                        check("bus_addr", bus_addr_o, bus_q.pop_front());
                    end else begin
                        n_checks++;
                        $display("FAIL bus_req: unexpected word at 0x%08h, expected none", bus_addr_o);
                    end
                end
            end else begin
                hready_i = 1'b0;
                hresp_i  = 1'b0;
                hrdata_i = '0;
            end
        end
    end

    // Monitor: pop and compare on every ready pulse; idle outputs stay 0.
    initial begin : monitor
        logic [W+1:0] e;
        forever begin
            @(negedge clk_i);
            #1;
            if (core_ready_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL ready_unexpected: got ready with rdata 0x%08h, expected no ready", core_rdata_o);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", core_rdata_o, e[W-1:0]);
                    check("err",   W'(core_err_o),  W'(e[W+1]));
                    check("hit",   W'(cache_hit_o), W'(e[W]));
                end
            end else begin
                check("idle_rdata", core_rdata_o, '0);
                check("idle_err",   W'(core_err_o), '0);
            end
        end
    end

    // Main sequence
    initial begin : main
        int busy_cnt;
        reset_i     = 1'b0;
        core_addr_i = '0;
        core_req_i  = 1'b0;
        flush_i     = 1'b0;

        // Reset: outputs zero during and after reset.
        repeat (3) @(negedge clk_i);
        #2;
        check_outputs_zero("in_reset");
        reset_i = 1'b1;
        @(negedge clk_i);
        #2;
        check_outputs_zero("post_reset");

        // Cold miss on 0x104.
        push_line(32'h100, 4);
        fetch(32'h104, 32'h104, 1'b0, 6);

        // Line neighbour hits with no bus traffic.
        fetch(32'h10C, 32'h10C, 1'b0, 1);

        // Conflict eviction; the refill back to 0x100 stalls 3 cycles on word 2.
        push_line(32'h500, 4);
        fetch(32'h504, 32'h504, 1'b0, 6);
        push_line(32'h100, 4);
        wait_word = 2;
        wait_left = 3;
        fetch(32'h104, 32'h104, 1'b0, 9);
        wait_word = -1;
        check("wait_consumed", W'(wait_left), '0);

        // Bus error on word 1, then a retry refilling from word 0.
        push_line(32'h320, 2);
        err_word = 1;
        fetch(32'h324, 32'h0, 1'b1, 3);
        err_word = -1;
        push_line(32'h320, 4);
        fetch(32'h324, 32'h324, 1'b0, 6);
        fetch(32'h104, 32'h104, 1'b0, 1);

        // Flush pulsed during a refill: refill completes, then a 16-cycle walk.
        push_line(32'h430, 4);
        fork
            fetch(32'h438, 32'h438, 1'b0, 6);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk_i);
                    if (bus_req_o) begin
                        flush_i = 1'b1;
                        @(negedge clk_i);
                        flush_i = 1'b0;
                        break;
                    end
                end
            end
        join
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            #2;
            if (flush_busy_o) busy_cnt++;
        end
        check("flush_cycles", W'(busy_cnt), W'(16));
        push_line(32'h100, 4);
        fetch(32'h104, 32'h104, 1'b0, 6);

        // Reset in the middle of a stalled refill: no ready, no error.
        bus_q.push_back(32'h640);
        wait_word = 0;
        wait_left = 100;
        @(negedge clk_i);
        core_addr_i = 32'h648;
        core_req_i  = 1'b1;
        repeat (4) @(negedge clk_i);
        #2;
        check("mid_refill_breq", W'(bus_req_o), W'(1));
        check("mid_refill_baddr", bus_addr_o, 32'h640);
        @(negedge clk_i);
        reset_i    = 1'b0;
        core_req_i = 1'b0;
        #2;
        check_outputs_zero("mid_reset");
        @(negedge clk_i);
        reset_i   = 1'b1;
        wait_word = -1;
        wait_left = 0;
        bus_q.delete();
        repeat (3) @(negedge clk_i);
        // Valid bits were cleared by reset, so this misses again.
        push_line(32'h100, 4);
        fetch(32'h104, 32'h104, 1'b0, 6);

        repeat (3) @(negedge clk_i);
        check("exp_q_drained", W'(exp_q.size()), '0);
        check("bus_q_drained", W'(bus_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
